encoder_8_3_sync: RTL

//  Clocked inverse of the 3-8 one-hot-low decoder: takes 8 active-low request lines
//  (keys/switches), synchronises them, optionally debounces, priority-encodes to a 3-bit code.
//  One code is presented per press on a valid/ready handshake; lines must all release

---
 rtl/encoder_8_3_sync.sv | 131 +++++++++++++
 1 files changed

// File: rtl/encoder_8_3_sync.sv
// encoder_8_3_sync: synchronised, optionally debounced (ENC_DEBOUNCE_EN) 8-to-3 priority encoder
// presenting one code per key press on a valid/ready handshake.
module encoder_8_3_sync #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_n,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_multi
);
    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RELEASE
`ifdef ENC_DEBOUNCE_EN
        , DEBOUNCE
`endif
    } state_t;

    state_t      r_state, n_state;
    logic [7:0]  r_s1, r_s2;
    logic [2:0]  r_code, n_code;
    logic        r_multi, n_multi;
    logic        r_valid, n_valid;
    logic [7:0]  w_src;
    logic [7:0]  w_low;
    logic [2:0]  w_code;
    logic        w_multi;
    logic        w_idle;

`ifdef ENC_DEBOUNCE_EN
    logic [7:0]       r_snap, n_snap;
    logic [CNT_W-1:0] r_cnt, n_cnt;
    assign w_src = r_snap;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{DB_CYCLES[0], CNT_W[0]};
    assign w_src = r_s2;
`endif

    function automatic logic [2:0] enc(input logic [7:0] v);
        enc = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (!v[i]) enc = i[2:0];
    endfunction

    // lowest-index low bit wins; multi when clearing that bit still leaves one low
    assign w_low   = ~w_src;
    assign w_code  = enc(w_src);
    assign w_multi = |(w_low & (w_low - 8'd1));
    assign w_idle  = (r_s2 == 8'hFF);

    always_comb begin
        n_state = r_state;
        n_code  = r_code;
        n_multi = r_multi;
        n_valid = r_valid;
`ifdef ENC_DEBOUNCE_EN
        n_snap  = r_snap;
        n_cnt   = r_cnt;
`endif
        case (r_state)
            IDLE: if (!w_idle) begin
`ifdef ENC_DEBOUNCE_EN
                n_snap  = r_s2;
                n_cnt   = '0;
                n_state = DEBOUNCE;
`else
                n_code  = w_code;
                n_multi = w_multi;
                n_valid = 1'b1;
                n_state = PRESENT;
`endif
            end
`ifdef ENC_DEBOUNCE_EN
            DEBOUNCE: begin
                if (w_idle) n_state = IDLE;
                else if (r_s2 != r_snap) begin
                    n_snap = r_s2;
                    n_cnt  = '0;
                end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                    n_code  = w_code;
                    n_multi = w_multi;
                    n_valid = 1'b1;
                    n_state = PRESENT;
                end else n_cnt = r_cnt + 1'b1;
            end
`endif
            PRESENT: if (out_ready) begin
                n_valid = 1'b0;
                n_state = RELEASE;
            end
            RELEASE: n_state = w_idle ? IDLE : RELEASE;
            default: n_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 8'hFF;
            r_s2    <= 8'hFF;
            r_state <= IDLE;
            r_code  <= 3'd0;
            r_multi <= 1'b0;
            r_valid <= 1'b0;
`ifdef ENC_DEBOUNCE_EN
            r_snap  <= 8'hFF;
            r_cnt   <= '0;
`endif
        end else begin
            r_s1    <= in_n;
            r_s2    <= r_s1;
            r_state <= n_state;
            r_code  <= n_code;
            r_multi <= n_multi;
            r_valid <= n_valid;
`ifdef ENC_DEBOUNCE_EN
            r_snap  <= n_snap;
            r_cnt   <= n_cnt;
`endif
        end
    end

    assign out_code  = r_code;
    assign out_multi = r_multi;
    assign out_valid = r_valid;
endmodule
